// File: rtl/ctrl_pkg.sv
// Shared opcodes, ALU-op encodings and per-stage control bundles for the
// pipelined MIPS control unit. Optional jal decode is enabled by CTRL_JAL_EN.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_LUI   = 3'b110;

    typedef struct packed {
        logic       valid;
        logic [2:0] alu_op;
        logic       alu_src;
        logic       reg_dst;
        logic       zext;
        logic       branch;
        logic       bne;
        logic       mem_wr;
        logic       mem_rd;
        logic       reg_wr;
        logic       mem2reg;
        logic       link;
    } ctrl_bundle_t;

    // Later stages only keep the fields still consumed downstream.
    typedef struct packed {
        logic valid;
        logic branch;
        logic bne;
        logic mem_wr;
        logic mem_rd;
        logic reg_wr;
        logic mem2reg;
        logic link;
    } mem_bundle_t;

    typedef struct packed {
        logic valid;
        logic reg_wr;
        logic mem2reg;
        logic link;
    } wb_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;
    localparam mem_bundle_t  MEM_BUBBLE  = '0;

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Control-unit bus: ID-stage inputs from the datapath/hazard logic and the
// per-stage control outputs (id_link/wb_link meaningful only with CTRL_JAL_EN).
interface pipe_ctrl_unit_if #(
    parameter int OP_W     = 6,
    parameter int ALU_OP_W = 3,
    parameter int CNT_W    = 8
);
    logic [OP_W-1:0]     op_code;
    logic                id_valid;
    logic                stall;
    logic                flush;
    logic                id_jmp;
    logic                id_link;
    logic                ex_valid;
    logic [ALU_OP_W-1:0] ex_alu_op;
    logic                ex_alu_src;
    logic                ex_reg_dst;
    logic                ex_branch;
    logic                ex_bne;
    logic                ex_zext;
    logic                mem_valid;
    logic                mem_wr;
    logic                mem_rd;
    logic                mem_branch;
    logic                mem_bne;
    logic                wb_valid;
    logic                wb_reg_wr;
    logic                wb_mem2reg;
    logic                wb_link;
    logic                illegal_flag;
    logic [CNT_W-1:0]    illegal_cnt;

    modport master (
        output op_code, id_valid, stall, flush,
        input  id_jmp, id_link,
        input  ex_valid, ex_alu_op, ex_alu_src, ex_reg_dst, ex_branch, ex_bne, ex_zext,
        input  mem_valid, mem_wr, mem_rd, mem_branch, mem_bne,
        input  wb_valid, wb_reg_wr, wb_mem2reg, wb_link,
        input  illegal_flag, illegal_cnt
    );

    modport slave (
        input  op_code, id_valid, stall, flush,
        output id_jmp, id_link,
        output ex_valid, ex_alu_op, ex_alu_src, ex_reg_dst, ex_branch, ex_bne, ex_zext,
        output mem_valid, mem_wr, mem_rd, mem_branch, mem_bne,
        output wb_valid, wb_reg_wr, wb_mem2reg, wb_link,
        output illegal_flag, illegal_cnt
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder producing the full control bundle, a jump
// indication and an illegal bit. Opcode 000011 decodes as jal only with CTRL_JAL_EN.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] op_code_i,
    output ctrl_bundle_t    bundle_o,
    output logic            jmp_o,
    output logic            illegal_o
);

    always_comb begin
        bundle_o  = CTRL_BUBBLE;
        jmp_o     = 1'b0;
        illegal_o = 1'b0;
        case (op_code_i)
            OP_W'(OP_LW): begin
                bundle_o.valid   = 1'b1;
                bundle_o.alu_op  = ALU_ADD;
                bundle_o.alu_src = 1'b1;
                bundle_o.mem_rd  = 1'b1;
                bundle_o.reg_wr  = 1'b1;
                bundle_o.mem2reg = 1'b1;
            end
            OP_W'(OP_SW): begin
                bundle_o.valid   = 1'b1;
                bundle_o.alu_op  = ALU_ADD;
                bundle_o.alu_src = 1'b1;
                bundle_o.mem_wr  = 1'b1;
            end
            OP_W'(OP_RTYPE): begin
                bundle_o.valid   = 1'b1;
                bundle_o.alu_op  = ALU_FUNCT;
                bundle_o.reg_dst = 1'b1;
                bundle_o.reg_wr  = 1'b1;
            end
            OP_W'(OP_ADDI): begin
                bundle_o.valid   = 1'b1;
                bundle_o.alu_op  = ALU_ADD;
                bundle_o.alu_src = 1'b1;
                bundle_o.reg_wr  = 1'b1;
            end
            OP_W'(OP_ANDI): begin
                bundle_o.valid   = 1'b1;
                bundle_o.alu_op  = ALU_AND;
                bundle_o.alu_src = 1'b1;
                bundle_o.zext    = 1'b1;
                bundle_o.reg_wr  = 1'b1;
            end
            OP_W'(OP_ORI): begin
                bundle_o.valid   = 1'b1;
                bundle_o.alu_op  = ALU_OR;
                bundle_o.alu_src = 1'b1;
                bundle_o.zext    = 1'b1;
                bundle_o.reg_wr  = 1'b1;
            end
            OP_W'(OP_SLTI): begin
                bundle_o.valid   = 1'b1;
                bundle_o.alu_op  = ALU_SLT;
                bundle_o.alu_src = 1'b1;
                bundle_o.reg_wr  = 1'b1;
            end
            OP_W'(OP_LUI): begin
                bundle_o.valid   = 1'b1;
                bundle_o.alu_op  = ALU_LUI;
                bundle_o.alu_src = 1'b1;
                bundle_o.reg_wr  = 1'b1;
            end
            OP_W'(OP_BEQ): begin
                bundle_o.valid  = 1'b1;
                bundle_o.alu_op = ALU_SUB;
                bundle_o.branch = 1'b1;
            end
            OP_W'(OP_BNE): begin
                bundle_o.valid  = 1'b1;
                bundle_o.alu_op = ALU_SUB;
                bundle_o.branch = 1'b1;
                bundle_o.bne    = 1'b1;
            end
            OP_W'(OP_J): begin
                bundle_o.valid = 1'b1;
                jmp_o          = 1'b1;
            end
`ifdef CTRL_JAL_EN
            OP_W'(OP_JAL): begin
                bundle_o.valid  = 1'b1;
                bundle_o.reg_wr = 1'b1;
                bundle_o.link   = 1'b1;
                jmp_o           = 1'b1;
            end
`endif
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes in ID and carries controls through ID/EX,
// EX/MEM and MEM/WB with stall/flush bubbles. Optional jal support via CTRL_JAL_EN.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int OP_W     = 6,
    parameter int ALU_OP_W = 3,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    pipe_ctrl_unit_if.slave  ctrl_if
);

    ctrl_bundle_t     id_bundle;
    logic             id_jmp;
    logic             id_illegal;
    logic             illegal_hit;

    ctrl_bundle_t     idex_d,  idex_q;
    mem_bundle_t      exmem_d, exmem_q;
    wb_bundle_t       memwb_d, memwb_q;
    logic             illegal_flag_d, illegal_flag_q;
    logic [CNT_W-1:0] illegal_cnt_d, illegal_cnt_q;

    ctrl_decode #(.OP_W(OP_W)) u_decode (
        .op_code_i (ctrl_if.op_code),
        .bundle_o  (id_bundle),
        .jmp_o     (id_jmp),
        .illegal_o (id_illegal)
    );

    always_comb begin
        idex_d = (ctrl_if.flush || ctrl_if.stall || !ctrl_if.id_valid) ? CTRL_BUBBLE : id_bundle;

        exmem_d = MEM_BUBBLE;
        if (!ctrl_if.flush) begin
            exmem_d.valid   = idex_q.valid;
            exmem_d.branch  = idex_q.branch;
            exmem_d.bne     = idex_q.bne;
            exmem_d.mem_wr  = idex_q.mem_wr;
            exmem_d.mem_rd  = idex_q.mem_rd;
            exmem_d.reg_wr  = idex_q.reg_wr;
            exmem_d.mem2reg = idex_q.mem2reg;
            exmem_d.link    = idex_q.link;
        end

        memwb_d.valid   = exmem_q.valid;
        memwb_d.reg_wr  = exmem_q.reg_wr;
        memwb_d.mem2reg = exmem_q.mem2reg;
        memwb_d.link    = exmem_q.link;

        // A held (stalled) or squashed instruction must not be counted again.
        illegal_hit    = ctrl_if.id_valid && !ctrl_if.stall && !ctrl_if.flush && id_illegal;
        illegal_flag_d = illegal_flag_q || illegal_hit;
        illegal_cnt_d  = illegal_cnt_q;
        if (illegal_hit && (illegal_cnt_q != {CNT_W{1'b1}}))
            illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex_q         <= CTRL_BUBBLE;
            exmem_q        <= MEM_BUBBLE;
            memwb_q        <= '0;
            illegal_flag_q <= 1'b0;
            illegal_cnt_q  <= '0;
        end else begin
            idex_q         <= idex_d;
            exmem_q        <= exmem_d;
            memwb_q        <= memwb_d;
            illegal_flag_q <= illegal_flag_d;
            illegal_cnt_q  <= illegal_cnt_d;
        end
    end

    assign ctrl_if.id_jmp       = id_jmp && ctrl_if.id_valid;

    assign ctrl_if.ex_valid     = idex_q.valid;
    assign ctrl_if.ex_alu_op    = ALU_OP_W'(idex_q.alu_op);
    assign ctrl_if.ex_alu_src   = idex_q.alu_src;
    assign ctrl_if.ex_reg_dst   = idex_q.reg_dst;
    assign ctrl_if.ex_branch    = idex_q.branch;
    assign ctrl_if.ex_bne       = idex_q.bne;
    assign ctrl_if.ex_zext      = idex_q.zext;

    assign ctrl_if.mem_valid    = exmem_q.valid;
    assign ctrl_if.mem_wr       = exmem_q.mem_wr;
    assign ctrl_if.mem_rd       = exmem_q.mem_rd;
    assign ctrl_if.mem_branch   = exmem_q.branch;
    assign ctrl_if.mem_bne      = exmem_q.bne;

    assign ctrl_if.wb_valid     = memwb_q.valid;
    assign ctrl_if.wb_reg_wr    = memwb_q.reg_wr;
    assign ctrl_if.wb_mem2reg   = memwb_q.mem2reg;

    assign ctrl_if.illegal_flag = illegal_flag_q;
    assign ctrl_if.illegal_cnt  = illegal_cnt_q;

`ifdef CTRL_JAL_EN
    assign ctrl_if.id_link = id_bundle.link && ctrl_if.id_valid;
    assign ctrl_if.wb_link = memwb_q.link;
`else
    // The decoder never sets link here, so the link bits are constant zero
    // and get trimmed; the outputs are tied off explicitly.
    logic unused_link;
    assign unused_link     = memwb_q.link;
    assign ctrl_if.id_link = 1'b0;
    assign ctrl_if.wb_link = 1'b0;
`endif

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Pipelined control unit for the 32-bit MIPS core. It decodes the ID-stage opcode into an extended control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers. Stall bubbles and branch flushes are applied at the register boundaries, so the datapath pipeline registers hold data only. It also detects illegal opcodes with a sticky flag and a saturating counter.

## Interface
Parameters:
- OP_W, 6, opcode width.
- ALU_OP_W, 3, width of the ALU-operation code sent to the ALU decoder.
- CNT_W, 8, width of the illegal-opcode counter.

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- op_code  in  OP_W  ID-stage opcode (instr[31:26]).
- id_valid  in  1  ID holds a real instruction.
- stall  in  1  from hazard unit: insert bubble into EX.
- flush  in  1  branch taken in MEM: kill ID/EX and EX/MEM contents.
- id_jmp  out  1  combinational jump in ID (j, jal).
- id_link  out  1  combinational jal in ID (0 without CTRL_JAL_EN).
- ex_valid, ex_alu_op[ALU_OP_W], ex_alu_src, ex_reg_dst, ex_branch, ex_bne, ex_zext  out  EX-stage controls.
- mem_valid, mem_wr, mem_rd, mem_branch, mem_bne  out  MEM-stage controls.
- wb_valid, wb_reg_wr, wb_mem2reg, wb_link  out  WB-stage controls.
- illegal_flag  out  1  sticky; set by any valid undecodable opcode.
- illegal_cnt  out  CNT_W  saturating count of illegal opcodes.

## Operation
- Decoded opcodes: lw 100011, sw 101011, R-type 000000, addi 001000, andi 001100, ori 001101, slti 001010, lui 001111, beq 000100, bne 000101, j 000010. jal 000011 is decoded only with CTRL_JAL_EN.
- ALU op codes: 000 add, 001 sub, 010 use funct, 011 and, 100 or, 101 slt, 110 lui.
  - lw, sw, addi → add. beq, bne → sub. R-type → use funct.
  - andi → and, with ex_zext=1. ori → or, with ex_zext=1.
  - slti → slt. lui → lui.
- Controls per opcode:
  - alu_src=1 for lw, sw and all immediates.
  - reg_dst=1 for R-type only.
  - reg_wr=1 for lw, R-type, immediates and jal.
  - mem2reg=1 for lw only. mem_rd=1 for lw only. mem_wr=1 for sw only.
  - branch=1 for beq and bne. bne=1 for bne only.
- Illegal or unsupported opcode: the bundle is all-zero with valid=0. The counter increments while below 2^CNT_W−1 and holds at saturation.
- A bubble is the all-zero bundle with valid=0. An all-zero bundle never writes memory or the register file.
- Register update order on each edge:
  - MEM/WB ← EX/MEM (never stalled or flushed).
  - EX/MEM ← bubble if flush, else ID/EX.
  - ID/EX ← bubble if flush, or stall, or !id_valid; else the decoded bundle.
- flush has priority over stall. With both asserted, ID/EX and EX/MEM both receive bubbles.
- Illegal detection is gated by id_valid, !stall and !flush, so a held instruction counts only once.

## Timing
- Reset: every registered output is 0, including all valid bits, illegal_flag and illegal_cnt. Reset clears in-flight bundles immediately, without waiting for a clock edge.
- id_jmp and id_link depend on op_code and id_valid only, with zero latency.
- Decode at edge n: ex_* visible after edge n, mem_* after edge n+1, wb_* after edge n+2.
- Stall held k cycles: k bubbles enter EX. The ID instruction enters EX on the first edge after stall deasserts.
- illegal_flag is set on the edge that samples the illegal opcode and clears only on rst.

## Configuration
- CTRL_JAL_EN defined: opcode 000011 decodes as jal.
  - id_jmp=1 and id_link=1.
  - reg_wr=1; wb_link=1 in WB selects r31 and PC+4.
- CTRL_JAL_EN undefined: 000011 is treated as illegal. id_link and wb_link are tied to 0 and their registers are removed.

## Structure
- Package ctrl_pkg:
  - opcode localparams.
  - ALU op encodings.
  - packed struct ctrl_bundle_t (valid, alu_op, alu_src, reg_dst, zext, branch, bne, mem_wr, mem_rd, reg_wr, mem2reg, link).
  - constant CTRL_BUBBLE.
- Sub-module ctrl_decode: purely combinational map from op_code to ctrl_bundle_t plus an illegal bit. The top level holds the three stage registers and the counter.

## Test plan
- Reset mid-stream: assert rst while lw is in EX → all outputs are 0 without waiting for an edge, and illegal_cnt=0.
- Sequence lw, sw, R-type, ori, beq on consecutive cycles → each bundle appears on ex_*, then mem_*, then wb_* in consecutive cycles with the listed encodings. ori gives ex_alu_op=100 and ex_zext=1.
- lw held with stall for 2 cycles → ex_valid=0 for 2 cycles, then lw appears in EX. illegal_cnt is unchanged.
- bne reaches MEM while flush=1 and stall=1 → the next ex_valid=0 and mem_valid=0. wb_valid follows the previous EX/MEM contents.
- Opcode 111111 held valid for 300 cycles with CNT_W=8 → illegal_flag=1 and illegal_cnt saturates at 255. No reg_wr or mem_wr asserts.
- Opcode 000011 → with CTRL_JAL_EN: id_jmp=1, id_link=1, and wb_link=1 with wb_reg_wr=1 three edges later. Without it: illegal_cnt increments and id_link=0.
